// File: rtl/bcd_to_bin16_if.sv
// Handshake bundle for the BCD-to-binary converter: digit input side and result output side.
// Latency: none; this is only a grouping of wires.
// Backpressure: in_valid/in_ready on the digit side, out_valid/out_ready on the result side.
interface bcd_to_bin16_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  bcd3;
  logic [3:0]  bcd2;
  logic [3:0]  bcd1;
  logic [3:0]  bcd0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bin;
  logic        out_err;

  // Producer of digits and consumer of results.
  modport master (
    output in_valid, bcd3, bcd2, bcd1, bcd0, out_ready,
    input  in_ready, out_valid, out_bin, out_err
  );

  // The converter itself.
  modport slave (
    input  in_valid, bcd3, bcd2, bcd1, bcd0, out_ready,
    output in_ready, out_valid, out_bin, out_err
  );
endinterface

// File: rtl/bcd_to_bin16.sv
// Converts 4 BCD digits to a 16-bit binary value by reverse double-dabble, one bit per clock.
// Latency: accept edge, then 16 shift edges; out_valid visible after the 16th shift (18 cycles/op at full rate).
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE.
module bcd_to_bin16 (
  input  logic           clk,
  input  logic           rst_n,
  bcd_to_bin16_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [31:0] sh;
  logic [31:0] sh_next;
  logic [3:0]  cnt;
  logic        err_r;
  logic        out_valid_r;
  logic [15:0] out_bin_r;
  logic        out_err_r;
  logic        digit_bad;

  assign digit_bad = (bus.bcd3 > 4'd9) || (bus.bcd2 > 4'd9) ||
                     (bus.bcd1 > 4'd9) || (bus.bcd0 > 4'd9);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.out_bin   = out_bin_r;
  assign bus.out_err   = out_err_r;

  // One reverse double-dabble step: shift right, then pull each BCD nibble that reached >=8 back by 3.
  always_comb begin
    sh_next = sh >> 1;
    for (int i = 0; i < 4; i++) begin
      if (sh_next[16 + 4*i +: 4] >= 4'd8) begin
        sh_next[16 + 4*i +: 4] = sh_next[16 + 4*i +: 4] - 4'd3;
      end
    end
  end

  // Control FSM with datapath registers; results are latched on the last shift and held until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sh          <= '0;
      cnt         <= '0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_bin_r   <= '0;
      out_err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sh    <= {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0, 16'd0};
            err_r <= digit_bad;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sh  <= sh_next;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            // Bad digits still run the full latency so timing does not depend on the data.
            out_bin_r   <= err_r ? 16'd0 : sh_next[15:0];
            out_err_r   <= err_r;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin16.sv
// Self-checking bench for bcd_to_bin16: directed and random conversions against an arithmetic model.
// Latency: checks the 16-edge accept-to-valid latency and the 18-cycle full-rate spacing.
// Backpressure: holds out_ready low to check result stability and in_ready blocking.
module tb_bcd_to_bin16;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  bcd_to_bin16_if bus ();

  bcd_to_bin16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case something unforeseen stalls the stimulus.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {err, value} from decimal arithmetic.
  function automatic logic [16:0] model(input int d3, input int d2, input int d1, input int d0);
    if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) return {1'b1, 16'd0};
    return {1'b0, 16'(d3 * 1000 + d2 * 100 + d1 * 10 + d0)};
  endfunction

  // Ticks until out_valid is seen, bounded; returns the number of edges taken.
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic accept(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
    bus.bcd3 = d3; bus.bcd2 = d2; bus.bcd1 = d1; bus.bcd0 = d0;
    bus.in_valid = 1'b1;
    chk("in_ready_before_accept", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    // Digits only matter on the accept edge; scramble them afterwards.
    bus.bcd3 = 4'($urandom); bus.bcd2 = 4'($urandom);
    bus.bcd1 = 4'($urandom); bus.bcd0 = 4'($urandom);
    chk("in_ready_after_accept", bus.in_ready, 0);
  endtask

  task automatic run_conv(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0,
                          input int hold);
    logic [16:0] e;
    int n;
    e = model(d3, d2, d1, d0);
    bus.out_ready = 1'b0;
    accept(d3, d2, d1, d0);
    wait_valid(n);
    chk("latency", n, 16);
    chk("out_bin", bus.out_bin, e[15:0]);
    chk("out_err", bus.out_err, e[16]);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_bin", bus.out_bin, e[15:0]);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("valid_drop", bus.out_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int          n;
    int          seen;
    logic [16:0] got;
    logic [3:0]  r3, r2, r1, r0;

    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.bcd3 = '0; bus.bcd2 = '0; bus.bcd1 = '0; bus.bcd0 = '0;

    // Reset values.
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_bin", bus.out_bin, 0);
    chk("rst_out_err", bus.out_err, 0);
    rst_n = 1'b1;

    // out_ready with nothing pending changes nothing.
    bus.out_ready = 1'b1;
    tick();
    chk("idle_out_ready_in_ready", bus.in_ready, 1);
    chk("idle_out_ready_valid", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // Largest value.
    run_conv(4'd9, 4'd9, 4'd9, 4'd9, 0);

    // Back-to-back at full rate: 0000 then 1234, in_valid and out_ready held high.
    bus.out_ready = 1'b1;
    accept(4'd0, 4'd0, 4'd0, 4'd0);
    bus.in_valid = 1'b1;
    bus.bcd3 = 4'd1; bus.bcd2 = 4'd2; bus.bcd1 = 4'd3; bus.bcd0 = 4'd4;
    n = 0; seen = 0; got = '1;
    while (n < 40) begin
      tick();
      n++;
      if (bus.out_valid === 1'b1) begin
        seen = 1;
        got = {bus.out_err, bus.out_bin};
      end
      if (bus.in_ready === 1'b1) break;
    end
    chk("b2b_first_seen", seen, 1);
    chk("b2b_first_result", got, model(0, 0, 0, 0));
    chk("b2b_accept_gap", n + 1, 18);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_second_accepted", bus.in_ready, 0);
    wait_valid(n);
    chk("b2b_second_latency", n, 16);
    chk("b2b_second_result", {bus.out_err, bus.out_bin}, model(1, 2, 3, 4));
    tick();
    chk("b2b_second_drop", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // Correction path, invalid digit, and backpressure.
    run_conv(4'd0, 4'd5, 4'd0, 4'd0, 0);
    run_conv(4'd0, 4'd0, 4'd0, 4'd8, 0);
    run_conv(4'd1, 4'hA, 4'd0, 4'd0, 0);
    run_conv(4'd0, 4'd0, 4'd4, 4'd2, 5);

    // Reset while shifting: abort, no result.
    accept(4'd9, 4'd9, 4'd9, 4'd9);
    bus.out_ready = 1'b1;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_out_bin", bus.out_bin, 0);
    seen = 0;
    repeat (20) begin
      tick();
      if (bus.out_valid !== 1'b0) seen = 1;
    end
    chk("abort_no_valid", seen, 0);
    run_conv(4'd9, 4'd9, 4'd9, 4'd9, 0);

    // Reset while holding a result.
    accept(4'd3, 4'd3, 4'd3, 4'd3);
    wait_valid(n);
    chk("done_rst_latency", n, 16);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("done_rst_valid", bus.out_valid, 0);
    chk("done_rst_bin", bus.out_bin, 0);
    chk("done_rst_in_ready", bus.in_ready, 1);

    // Random digits, mostly legal, with occasional bad nibbles and random stalls.
    for (int k = 0; k < 10; k++) begin
      r3 = 4'($urandom_range(0, 9)); r2 = 4'($urandom_range(0, 9));
      r1 = 4'($urandom_range(0, 9)); r0 = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) r1 = 4'($urandom_range(10, 15));
      run_conv(r3, r2, r1, r0, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
